wb_arbiter: RTL and testbench



---
 rtl/cpu_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 70 +++++++
 rtl/wb_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: register-file widths and the writeback queue entry.
// Imported by the writeback arbiter and its result queue.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              squash;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_MDU
  } wb_sel_t;

  function automatic logic wb_commits(wb_entry_t e);
    return (e.addr != '0) && !e.squash;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// MDU result queue for the writeback arbiter.
// Entries whose address matches the squash port are marked dead in place.
module wb_fifo #(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  cpu_pkg::wb_entry_t        push_entry,
  input  logic                      pop,
  output cpu_pkg::wb_entry_t        head,
  output logic                      full,
  output logic                      empty,
  output logic [CW-1:0]             count,
  input  logic                      sq_en,
  input  logic [cpu_pkg::ADDR_W-1:0] sq_addr
);
  import cpu_pkg::*;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;
  logic            push_hit;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign head     = mem[rd_ptr];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign push_hit = sq_en && (push_entry.addr == sq_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sq_en && (mem[i].addr == sq_addr)) begin
          mem[i].squash <= 1'b1;
        end
      end
      // a same-cycle push overrides the loop above for its slot
      if (push_ok) begin
        mem[wr_ptr].addr   <= push_entry.addr;
        mem[wr_ptr].data   <= push_entry.data;
        mem[wr_ptr].squash <= push_entry.squash | push_hit;
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results win, MDU results queue,
// stale MDU results are squashed, starvation raises stall_req.
module wb_arbiter #(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int ADDR_W     = cpu_pkg::ADDR_W,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic [ADDR_W-1:0] r3_addr,
  output logic [DATA_W-1:0] r3_din,
  output logic              r3_wr,
  output logic              stall_req,
  output logic [CW-1:0]     pend_cnt
);
  import cpu_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  wb_entry_t         push_entry;
  wb_entry_t         head;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              sq_en;
  wb_sel_t           sel;

  logic [SW-1:0]     starve_q;
  logic [SW-1:0]     starve_d;
  logic              stall_d;
  logic              wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;

  assign mdu_ready = !full;
  assign push      = mdu_valid && !full;
  assign pop       = (sel == SEL_MDU);
  assign sq_en     = alu_valid && (alu_addr != '0);
  assign pend_cnt  = count;

  assign push_entry = '{
    addr:   mdu_addr,
    data:   mdu_data,
    squash: 1'b0
  };

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .sq_en      (sq_en),
    .sq_addr    (alu_addr)
  );

  always_comb begin
    sel = SEL_NONE;
    if (alu_valid) begin
      sel = SEL_ALU;
    end else if (!empty) begin
      sel = SEL_MDU;
    end
  end

  always_comb begin
    wr_d   = 1'b0;
    addr_d = r3_addr;
    din_d  = r3_din;
    unique case (sel)
      SEL_ALU: begin
        wr_d   = (alu_addr != '0);
        addr_d = alu_addr;
        din_d  = alu_data;
      end
      SEL_MDU: begin
        wr_d   = wb_commits(head);
        addr_d = head.addr;
        din_d  = head.data;
      end
      default: begin
        wr_d = 1'b0;
      end
    endcase
  end

  // the head only loses to the ALU here, so non-empty without pop means a loss
  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (starve_q != SMAX) begin
      starve_d = starve_q + 1'b1;
    end
    stall_d = (starve_d == SMAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r3_wr     <= 1'b0;
      r3_addr   <= '0;
      r3_din    <= '0;
      stall_req <= 1'b0;
      starve_q  <= '0;
    end else begin
      r3_wr     <= wr_d;
      r3_addr   <= addr_d;
      r3_din    <= din_d;
      stall_req <= stall_d;
      starve_q  <= starve_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: cycle vector table plus a
// scoreboarded drain sequence.
module tb_wb_arbiter;
  import cpu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  localparam int SMAX = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_addr;
  logic [DW-1:0] mdu_data;
  logic [AW-1:0] r3_addr;
  logic [DW-1:0] r3_din;
  logic          r3_wr;
  logic          stall_req;
  logic [CW-1:0] pend_cnt;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .DEPTH      (DEPTH),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .r3_addr   (r3_addr),
    .r3_din    (r3_din),
    .r3_wr     (r3_wr),
    .stall_req (stall_req),
    .pend_cnt  (pend_cnt)
  );

  typedef struct {
    logic          rst_n;
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          wr;
    logic          ad_chk;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          rdy;
    logic          stall;
    logic [CW-1:0] pend;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  vec_t vecs[$];
  vec_t sb[$];
  wr_t  exp_q[$];
  int   passed = 0;
  int   total = 0;

  task automatic add(
    input int r, input int av, input int aa, input logic [31:0] ad,
    input int mv, input int ma, input logic [31:0] md,
    input int wr, input int chk, input int ea, input logic [31:0] ed,
    input int rdy, input int st, input int pd
  );
    vec_t t;
    t.rst_n  = 1'(r);
    t.av     = 1'(av);
    t.aa     = AW'(aa);
    t.ad     = ad;
    t.mv     = 1'(mv);
    t.ma     = AW'(ma);
    t.md     = md;
    t.wr     = 1'(wr);
    t.ad_chk = 1'(chk);
    t.ea     = AW'(ea);
    t.ed     = ed;
    t.rdy    = 1'(rdy);
    t.stall  = 1'(st);
    t.pend   = CW'(pd);
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got %h expected %h", nm, got, exp);
  endtask

  task automatic cyc();
    wr_t e;
    @(posedge clk);
    #1;
    if (r3_wr) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL drain unexpected write addr %0d data %h", r3_addr, r3_din);
      end else begin
        e = exp_q.pop_front();
        if (r3_addr === e.addr && r3_din === e.data) passed++;
        else $display("FAIL drain write got %0d/%h expected %0d/%h",
                      r3_addr, r3_din, e.addr, e.data);
      end
    end
  endtask

  initial begin
    vec_t e;
    rst_n = 1'b0;
    alu_valid = 1'b0;
    alu_addr = '0;
    alu_data = '0;
    mdu_valid = 1'b0;
    mdu_addr = '0;
    mdu_data = '0;

    //  r av aa ad            mv ma md         wr ck ea ed            rdy st pd
    add(0, 1, 5, 32'h1,        1, 3, 32'h9,    0, 1, 0, 32'h0,        1, 0, 0);
    add(0, 1, 5, 32'h1,        1, 3, 32'h9,    0, 1, 0, 32'h0,        1, 0, 0);
    add(1, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,    1, 1, 5, 32'hDEADBEEF, 1, 0, 0);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 32'h0,        1, 0, 0);
    add(1, 0, 0, 32'h0,        1, 7, 32'h1234, 0, 0, 0, 32'h0,        1, 0, 1);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 7, 32'h1234,     1, 0, 0);
    add(1, 0, 0, 32'h0,        1, 0, 32'h55,   0, 0, 0, 32'h0,        1, 0, 1);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 32'h0,        1, 0, 0);
    add(1, 1, 10, 32'h100,     1, 3, 32'h1,    1, 1, 10, 32'h100,     1, 0, 1);
    add(1, 1, 11, 32'h101,     1, 4, 32'h2,    1, 1, 11, 32'h101,     0, 0, 2);
    add(1, 1, 12, 32'h102,     1, 8, 32'h3,    1, 1, 12, 32'h102,     0, 0, 2);
    add(1, 1, 13, 32'h103,     0, 0, 32'h0,    1, 1, 13, 32'h103,     0, 1, 2);
    add(1, 1, 14, 32'h104,     0, 0, 32'h0,    1, 1, 14, 32'h104,     0, 1, 2);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 3, 32'h1,        1, 0, 1);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 4, 32'h2,        1, 0, 0);
    add(1, 0, 0, 32'h0,        1, 9, 32'hAAAA, 0, 0, 0, 32'h0,        1, 0, 1);
    add(1, 1, 9, 32'hBBBB,     0, 0, 32'h0,    1, 1, 9, 32'hBBBB,     1, 0, 1);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 32'h0,        1, 0, 0);
    add(1, 1, 6, 32'h2,        1, 6, 32'h1,    1, 1, 6, 32'h2,        1, 0, 1);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 32'h0,        1, 0, 0);
    add(1, 1, 0, 32'h77,       0, 0, 32'h0,    0, 0, 0, 32'h0,        1, 0, 0);
    add(1, 0, 0, 32'h0,        1, 1, 32'h11,   0, 0, 0, 32'h0,        1, 0, 1);
    add(1, 0, 0, 32'h0,        1, 2, 32'h22,   1, 1, 1, 32'h11,       1, 0, 1);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 2, 32'h22,       1, 0, 0);
    add(1, 0, 0, 32'h0,        1, 20, 32'hC1,  0, 0, 0, 32'h0,        1, 0, 1);
    add(1, 1, 15, 32'h5,       1, 21, 32'hC2,  1, 1, 15, 32'h5,       0, 0, 2);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 1, 0, 32'h0,        1, 0, 0);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 32'h0,        1, 0, 0);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 32'h0,        1, 0, 0);

    foreach (vecs[i]) begin
      rst_n     = vecs[i].rst_n;
      alu_valid = vecs[i].av;
      alu_addr  = vecs[i].aa;
      alu_data  = vecs[i].ad;
      mdu_valid = vecs[i].mv;
      mdu_addr  = vecs[i].ma;
      mdu_data  = vecs[i].md;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d r3_wr", i), 32'(r3_wr), 32'(e.wr));
      chk($sformatf("v%0d mdu_ready", i), 32'(mdu_ready), 32'(e.rdy));
      chk($sformatf("v%0d stall_req", i), 32'(stall_req), 32'(e.stall));
      chk($sformatf("v%0d pend_cnt", i), 32'(pend_cnt), 32'(e.pend));
      if (e.wr || e.ad_chk) begin
        chk($sformatf("v%0d r3_addr", i), 32'(r3_addr), 32'(e.ea));
        chk($sformatf("v%0d r3_din", i), r3_din, e.ed);
      end
    end

    // two MDU results queued behind ALU traffic, then drained in order
    alu_valid = 1'b1; alu_addr = 5'd18; alu_data = 32'h1;
    mdu_valid = 1'b1; mdu_addr = 5'd16; mdu_data = 32'hA;
    exp_q.push_back('{addr: 5'd18, data: 32'h1});
    cyc();
    alu_valid = 1'b1; alu_addr = 5'd19; alu_data = 32'h2;
    mdu_valid = 1'b1; mdu_addr = 5'd17; mdu_data = 32'hB;
    exp_q.push_back('{addr: 5'd19, data: 32'h2});
    cyc();
    alu_valid = 1'b0;
    mdu_valid = 1'b0;
    exp_q.push_back('{addr: 5'd16, data: 32'hA});
    exp_q.push_back('{addr: 5'd17, data: 32'hB});
    for (int n = 0; n < 8 && exp_q.size() != 0; n++) cyc();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_pend", 32'(pend_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
